// File: rtl/b4_strg_pkg.sv
// Shared types and helpers for the b4_strg storage-register sequencer.
// The optional parity state is enabled by B4_STRG_SEQ_PARITY_EN.
package b4_strg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_PAR   = 3'd4
    } state_t;

    // One counter serves both SHIFT and GAP, so it must hold the larger of the two.
    function automatic int cnt_width(input int width, input int gap);
        int m;
        m = (width > gap) ? width : gap;
        return $clog2(m + 1);
    endfunction

    function automatic int word_period(input int width, input int gap, input int par);
        return 2 + width + gap + par;
    endfunction

    function automatic logic word_parity(input logic [15:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/b4_strg_cnt.sv
// Terminal-count down-counter with synchronous load, shared by the SHIFT and GAP phases.
module b4_strg_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = (count_r == {W{1'b0}});

endmodule

// File: rtl/b4_strg_seq.sv
// Load/shift sequencer for the 4-bit parallel-load storage register.
// Define B4_STRG_SEQ_PARITY_EN to add the PAR state (even parity of the held word).
module b4_strg_seq
    import b4_strg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sr_load,
    output logic [WIDTH-1:0] sr_data,
    output logic             shift_en,
    output logic             sync,
    output logic             busy,
    output logic             par_bit,
    output logic             par_valid
);

    localparam int CNT_W    = cnt_width(WIDTH, GAP);
    localparam int SHIFT_M1 = WIDTH - 1;
    localparam int GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [CNT_W-1:0] SHIFT_LD = SHIFT_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] GAP_LD   = GAP_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit HAS_GAP = (GAP > 0);
`ifdef B4_STRG_SEQ_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
    localparam bit B2B    = (GAP == 0);
`endif

    state_t           state_r;
    logic [WIDTH-1:0] hold_r;
    logic             in_ready_r;
    logic             sr_load_r;
    logic             shift_en_r;
    logic             sync_r;
    logic             busy_r;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_dec_s;
    logic [CNT_W-1:0] cnt_s;
    logic             cnt_tc_s;

    // Counter control: reload on entry to SHIFT or GAP, count down while inside.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_val_s  = {CNT_W{1'b0}};
        cnt_dec_s  = 1'b0;
        case (state_r)
            ST_LOAD: begin
                cnt_load_s = 1'b1;
                cnt_val_s  = SHIFT_LD;
            end
            ST_SHIFT: begin
                if (cnt_tc_s) begin
                    if (!PAR_EN && HAS_GAP) begin
                        cnt_load_s = 1'b1;
                        cnt_val_s  = GAP_LD;
                    end else begin
                        cnt_load_s = 1'b0;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_PAR: begin
                if (HAS_GAP) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = GAP_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_GAP:  cnt_dec_s = 1'b1;
            default: cnt_dec_s = 1'b0;
        endcase
    end

    b4_strg_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .dec      (cnt_dec_s),
        .count    (cnt_s),
        .tc       (cnt_tc_s)
    );

`ifdef B4_STRG_SEQ_PARITY_EN
    logic par_bit_r;
    logic par_valid_r;
    assign par_bit   = par_bit_r;
    assign par_valid = par_valid_r;
`else
    assign par_bit   = 1'b0;
    assign par_valid = 1'b0;
`endif

    // State machine; every output is set for the state being entered so it is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            hold_r     <= {WIDTH{1'b0}};
            in_ready_r <= 1'b1;
            sr_load_r  <= 1'b0;
            shift_en_r <= 1'b0;
            sync_r     <= 1'b0;
            busy_r     <= 1'b0;
`ifdef B4_STRG_SEQ_PARITY_EN
            par_bit_r   <= 1'b0;
            par_valid_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        hold_r     <= in_data;
                        state_r    <= ST_LOAD;
                        in_ready_r <= 1'b0;
                        sr_load_r  <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_r    <= ST_SHIFT;
                    sr_load_r  <= 1'b0;
                    shift_en_r <= 1'b1;
                    sync_r     <= 1'b1;
                    in_ready_r <= 1'b0;
                end
                ST_SHIFT: begin
                    sync_r <= 1'b0;
                    if (cnt_tc_s) begin
                        shift_en_r <= 1'b0;
`ifdef B4_STRG_SEQ_PARITY_EN
                        state_r     <= ST_PAR;
                        par_valid_r <= 1'b1;
                        par_bit_r   <= word_parity(16'(hold_r));
                        in_ready_r  <= 1'b0;
                        busy_r      <= 1'b1;
`else
                        // Back-to-back: the handshake taken in the last shift cycle goes straight to LOAD.
                        if (B2B && in_valid && in_ready_r) begin
                            hold_r     <= in_data;
                            state_r    <= ST_LOAD;
                            sr_load_r  <= 1'b1;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end else if (HAS_GAP) begin
                            state_r    <= ST_GAP;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            state_r    <= ST_IDLE;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                        end
`endif
                    end else begin
                        shift_en_r <= 1'b1;
`ifdef B4_STRG_SEQ_PARITY_EN
                        in_ready_r <= 1'b0;
`else
                        in_ready_r <= B2B && (cnt_s == CNT_ONE);
`endif
                    end
                end
                ST_PAR: begin
`ifdef B4_STRG_SEQ_PARITY_EN
                    par_valid_r <= 1'b0;
`endif
                    if (HAS_GAP) begin
                        state_r    <= ST_GAP;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (cnt_tc_s) begin
                        state_r    <= ST_IDLE;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end else begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b1;
                    sr_load_r  <= 1'b0;
                    shift_en_r <= 1'b0;
                    sync_r     <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign sr_load  = sr_load_r;
    assign sr_data  = hold_r;
    assign shift_en = shift_en_r;
    assign sync     = sync_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_b4_strg_seq.sv
// Directed bench for b4_strg_seq: one GAP=0 instance and one GAP=3 instance.
module tb_b4_strg_seq;

`ifdef B4_STRG_SEQ_PARITY_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       iv, iv_g;
    logic [3:0] id, id_g;
    logic       rdy, ld, sh, sy, bz, pb, pv;
    logic [3:0] sd;
    logic       rdy_g, ld_g, sh_g, sy_g, bz_g, pb_g, pv_g;
    logic [3:0] sd_g;
    logic [3:0] piso;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    b4_strg_seq #(.WIDTH(4), .GAP(0)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_data(id), .in_ready(rdy),
        .sr_load(ld), .sr_data(sd), .shift_en(sh), .sync(sy), .busy(bz),
        .par_bit(pb), .par_valid(pv)
    );

    b4_strg_seq #(.WIDTH(4), .GAP(3)) dut_g (
        .clk(clk), .rst(rst), .in_valid(iv_g), .in_data(id_g), .in_ready(rdy_g),
        .sr_load(ld_g), .sr_data(sd_g), .shift_en(sh_g), .sync(sy_g), .busy(bz_g),
        .par_bit(pb_g), .par_valid(pv_g)
    );

    // Reference PISO register fed by the sequencer strobes; emits its MSB on each shift.
    always @(posedge clk) begin
        if (ld) piso <= sd;
        else if (sh) piso <= {piso[2:0], 1'b0};
    end

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       rdy, ld;
        logic [3:0] sd;
        logic       sh, sy, bz, pv, pb;
    } vec_t;

    vec_t tv[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [3:0] ser, w0, w1;
    int busy_n, sync_n, sync_at, hs, nl, np, nsh, bad, quiet;
    int hs_at[4], load_at[4], par_at[4];
    logic par_bits[4];
    logic rdy5;

    initial begin
        // Single word 4'b1011 after reset (hold register still 0 in the first row).
        tv[0] = '{1'b1, 4'hB, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'hB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 4'h0, (PE == 0), 1'b0, 4'hB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        if (PE == 1) tv[6] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        else         tv[6] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[7] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; iv = 1'b0; id = 4'h0; iv_g = 1'b0; id_g = 4'h0;
        tick(); tick();
        check("reset", {rdy, ld, sd, sh, sy, bz, pv, pb}, {1'b1, 1'b0, 4'h0, 5'b0});
        check("reset_g", {rdy_g, ld_g, sd_g, sh_g, sy_g, bz_g, pv_g, pb_g}, {1'b1, 1'b0, 4'h0, 5'b0});
        rst = 1'b0;
        tick();

        // Single word, table-driven.
        ser = 4'h0; busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            iv = tv[i].v; id = tv[i].d;
            check($sformatf("t2_vec%0d", i), {rdy, ld, sd, sh, sy, bz, pv, pb},
                  {tv[i].rdy, tv[i].ld, tv[i].sd, tv[i].sh, tv[i].sy, tv[i].bz, tv[i].pv, tv[i].pb});
            if (bz) busy_n++;
            if (sh) ser = {ser[2:0], piso[3]};
            tick();
        end
        check("t2_serial", ser, 4'b1011);
        check("t2_cycles_from_hs", busy_n + 1, 6 + PE);

        // Reset in the third shift cycle, then a fresh word.
        iv = 1'b1; id = 4'h5;
        tick();
        iv = 1'b0;
        tick(); tick(); tick();
        check("t1_in_shift", {sh, sy}, 2'b10);
        rst = 1'b1;
        #1;
        check("t1_async", {rdy, bz, ld, sh, sy}, 5'b10000);
        tick();
        rst = 1'b0;
        iv = 1'b1; id = 4'hA;
        tick();
        iv = 1'b0;
        ser = 4'h0; sync_n = 0; sync_at = -1;
        for (int k = 1; k <= 6; k++) begin
            if (sy) begin sync_n++; sync_at = k; end
            if (sh) ser = {ser[2:0], piso[3]};
            tick();
        end
        check("t1_sync_count", sync_n, 1);
        check("t1_sync_pos", sync_at, 2);
        check("t1_serial", ser, 4'hA);
        check("t1_idle", {rdy, bz, sd}, {1'b1, 1'b0, 4'hA});

        // Two words with in_valid held high.
        w0 = (PE == 1) ? 4'b0111 : 4'h3;
        w1 = (PE == 1) ? 4'b0110 : 4'hC;
        hs = 0; nl = 0; np = 0; nsh = 0; rdy5 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            iv = (hs < 2); id = (hs == 0) ? w0 : w1;
            if (k == 5) rdy5 = rdy;
            if (rdy && iv && hs < 4) begin hs_at[hs] = k; hs++; end
            if (ld && nl < 4) begin load_at[nl] = k; nl++; end
            if (pv && np < 4) begin par_at[np] = k; par_bits[np] = pb; np++; end
            if (sh) nsh++;
            tick();
        end
        iv = 1'b0;
        check("t3_hs_count", hs, 2);
        check("t3_hs2_cycle", hs_at[1], (PE == 1) ? 7 : 5);
        check("t3_load_period", load_at[1] - load_at[0], (PE == 1) ? 7 : 5);
        check("t3_shift_cycles", nsh, 8);
        check("t3_ready_last_shift", rdy5, (PE == 0));
        check("t3_shift_spacing", (load_at[1] + 1) - 5, (PE == 1) ? 4 : 2);
        if (PE == 1) begin
            check("t6_par_count", np, 2);
            check("t6_par_pos", {par_at[0], par_at[1]}, {32'd6, 32'd13});
            check("t6_par_bits", {par_bits[0], par_bits[1]}, 2'b10);
        end else begin
            check("t6_no_par", np, 0);
        end

        // in_data churns while the word is in flight; in_valid held during non-ready cycles.
        iv = 1'b1; id = 4'h9;
        tick();
        hs = 0; bad = 0;
        for (int k = 1; k <= 6; k++) begin
            iv = (k <= 3);
            id = 4'($urandom_range(0, 15));
            if (rdy && iv) hs++;
            if (sd !== 4'h9) bad++;
            tick();
        end
        iv = 1'b0;
        check("t5_extra_accepts", hs, 0);
        check("t5_sr_data_unstable", bad, 0);
        check("t5_end", {rdy, bz, sd}, {1'b1, 1'b0, 4'h9});

        // GAP=3 instance, two words.
        hs = 0; quiet = 0;
        for (int k = 0; k < 25; k++) begin
            iv_g = (hs < 2); id_g = (hs == 0) ? 4'h6 : 4'h9;
            if (rdy_g && iv_g && hs < 4) begin hs_at[hs] = k; hs++; end
            if (bz_g && !ld_g && !sh_g && !sy_g && !pv_g && !rdy_g) quiet++;
            tick();
        end
        iv_g = 1'b0;
        check("t4_hs2_cycle", hs_at[1], 9 + PE);
        check("t4_gap_cycles", quiet, 6);
        check("t4_end", {rdy_g, bz_g, sd_g}, {1'b1, 1'b0, 4'h9});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
